smart_home_ctrl_p: RTL and testbench
====================================

// Module: smart_home_ctrl_p
// PURPOSE
//  Parametrised smart-home controller: next generation of the single-window, fixed-threshold controller.
//  Debounces door, window and fire sensors, and supports N_WIN window zones.
//  Runs a priority FSM; heater/cooler thresholds are set by parameter, with hysteresis.
//  Sits between raw sensor pins and actuator/buzzer/display drivers.
// PARAMETERS
//  TEMP_W    7   temperature bus width, unsigned
//  N_WIN     4   number of window sensors (>=1)
//  DEBOUNCE  4   consecutive stable sampled cycles before a sensor change is accepted (>=1)
//  T_LOW     50  heater turns on when ST < T_LOW
//  T_HIGH    60  cooler turns on when ST > T_HIGH; T_LOW < T_HIGH required (elaboration assertion)
//  HYST      2   hysteresis band, in temperature LSBs
// PORTS
//  clk        in   1             single clock, rising edge
//  Rst        in   1             asynchronous, active-low reset
//  SFD        in   1             front door open (raw, async)
//  SRD        in   1             rear door open (raw, async)
//  SW         in   N_WIN         window open per zone (raw, async)
//  SFA        in   1             fire alarm sensor (raw, async)
//  ST         in   TEMP_W        temperature (synchronous to clk)
//  alarm_ack  in   1             operator acknowledge for latched fire alarm
//  fdoor      out  1             front door actuator
//  rdoor      out  1             rear door actuator
//  winbuzz    out  1             window buzzer
//  win_zone   out  clog2(N_WIN)  index of lowest-numbered open window (max(1,..) bits)
//  alarmbuzz  out  1             fire buzzer
//  heater     out  1             heater on
//  cooler     out  1             cooler on
//  display    out  3             current state code
// BEHAVIOUR
//  Reset (Rst=0, async): state=IDLE; all outputs 0, win_zone=0.
//    Debouncers cleared to 0; fire latch cleared; ST register cleared.
//  Sensor path: 2-flop sync, then debounce counter; filtered value changes on the edge where the counter hits DEBOUNCE.
//    Any mismatch restarts the count.
//  ST is registered once; not debounced.
//  State codes (display=code): IDLE 000, FRONT 001, REAR 010, FIRE 011, WIN 100, HEAT 101, COOL 110. Code 111 is unused.
//    An illegal 111 recovers to IDLE next cycle.
//  Outputs are decoded from the state register only, with one active output per state.
//    win_zone is registered and updates every cycle in WIN; it holds its value elsewhere.
//  Next state is evaluated every cycle, in fixed priority:
//    FIRE > FRONT (SFD) > REAR (SRD) > WIN (any SW) > HEAT/COOL > IDLE.
//  Simultaneous events: highest priority wins; lower events are served once higher ones clear.
//  HEAT: enter when ST < T_LOW; stay until ST >= T_LOW+HYST.
//  COOL: enter when ST > T_HIGH; stay until ST <= T_HIGH-HYST.
//  Pre-emption out of HEAT/COOL discards the hysteresis; re-entry uses the entry thresholds.
//  Latency: raw sensor edge to output = 2+DEBOUNCE+1 cycles; ST change to output = 2 cycles.
//  A sensor glitch shorter than DEBOUNCE sampled cycles produces no state change.
// CONFIGURATION
//  SH_FIRE_LATCH_EN defined:
//    FIRE is entered on filtered SFA=1 and latched.
//    Exit happens only on the edge where alarm_ack=1 AND filtered SFA=0.
//    Ack while SFA=1 is ignored and not remembered.
//  SH_FIRE_LATCH_EN undefined: FIRE follows filtered SFA; alarm_ack is ignored.
// STRUCTURE
//  sh_pkg: state_t enum with the codes above, SH_SYNC_STAGES=2, helper function for win_zone width.
//  Sub-module sh_debounce (parameter DEBOUNCE): 2-flop sync + counter, one instance per sensor bit.
//    Instantiated 3+N_WIN times via generate.
//  Top holds the ST register, FSM, hysteresis compare, win_zone priority encoder and output decode.
// TESTING
//  Defaults used throughout.
//  1. Reset mid-HEAT (Rst low for 3 cycles) -> outputs 0, display=000 immediately and asynchronously, before any clk edge.
//  2. SFD=1 and SW=4'b0110 raised together -> fdoor=1, display=001 after 7 cycles.
//     Then drop SFD -> 7 cycles later winbuzz=1, win_zone=1.
//  3. SRD pulse of 3 cycles -> no change; pulse of 7 cycles -> rdoor=1 for 7 cycles, starting 7 cycles after the rising edge.
//  4. ST=49 -> heater=1 after 2 cycles; ST=51 -> heater stays 1; ST=52 -> heater=0.
//     ST=61 -> cooler=1; ST=59 -> cooler stays 1; ST=58 -> cooler=0.
//  5. SH_FIRE_LATCH_EN: SFA=1 -> alarmbuzz=1; ack while SFA=1 -> alarmbuzz stays 1.
//     SFA=0 -> alarmbuzz stays 1; ack=1 -> alarmbuzz=0 next edge, state goes to the next pending event.
//  6. Without the macro, same stimulus -> alarmbuzz drops 7 cycles after SFA falls; ack has no effect.

Source files
------------

// File: rtl/sh_pkg.sv
// Shared types and constants for the smart-home controller: state codes,
// synchroniser depth and the window-zone index width helper.
package sh_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_FRONT = 3'b001,
        S_REAR  = 3'b010,
        S_FIRE  = 3'b011,
        S_WIN   = 3'b100,
        S_HEAT  = 3'b101,
        S_COOL  = 3'b110
    } state_t;

    localparam int SH_SYNC_STAGES = 2;

    // A single window still needs a one-bit zone index.
    function automatic int sh_zone_w(input int n_win);
        return (n_win > 1) ? $clog2(n_win) : 1;
    endfunction

endpackage

// File: rtl/sh_debounce.sv
// One sensor bit: two-flop synchroniser followed by a stability counter; the
// filtered value flips on the edge where DEBOUNCE consecutive differing samples are seen.
module sh_debounce
    import sh_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [SH_SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      sample;

    assign sample = sync_q[SH_SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SH_SYNC_STAGES-2:0], raw};
            // Any sample that agrees with the accepted value restarts the count.
            if (sample == filt) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                filt  <= sample;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/smart_home_ctrl_p.sv
// Smart-home controller: debounced door/window/fire sensors, priority FSM and
// heater/cooler with hysteresis. Define SH_FIRE_LATCH_EN to latch FIRE until acknowledged.
module smart_home_ctrl_p
    import sh_pkg::*;
#(
    parameter int TEMP_W   = 7,
    parameter int N_WIN    = 4,
    parameter int DEBOUNCE = 4,
    parameter int T_LOW    = 50,
    parameter int T_HIGH   = 60,
    parameter int HYST     = 2
) (
    input  logic                        clk,
    input  logic                        Rst,
    input  logic                        SFD,
    input  logic                        SRD,
    input  logic [N_WIN-1:0]            SW,
    input  logic                        SFA,
    input  logic [TEMP_W-1:0]           ST,
    input  logic                        alarm_ack,
    output logic                        fdoor,
    output logic                        rdoor,
    output logic                        winbuzz,
    output logic [sh_zone_w(N_WIN)-1:0] win_zone,
    output logic                        alarmbuzz,
    output logic                        heater,
    output logic                        cooler,
    output logic [2:0]                  display
);

    localparam int ZONE_W = sh_zone_w(N_WIN);
    localparam int N_SENS = 3 + N_WIN;

    localparam logic [TEMP_W-1:0] HEAT_ON  = TEMP_W'(T_LOW);
    localparam logic [TEMP_W-1:0] HEAT_OFF = TEMP_W'(T_LOW + HYST);
    localparam logic [TEMP_W-1:0] COOL_ON  = TEMP_W'(T_HIGH);
    localparam logic [TEMP_W-1:0] COOL_OFF = TEMP_W'(T_HIGH - HYST);

    if (T_LOW >= T_HIGH) begin : g_thr_check
        $error("smart_home_ctrl_p: T_LOW must be below T_HIGH");
    end

    logic [N_SENS-1:0] sens_raw;
    logic [N_SENS-1:0] sens_f;
    logic              sfd_f;
    logic              srd_f;
    logic              sfa_f;
    logic [N_WIN-1:0]  sw_f;

    assign sens_raw = {SW, SFA, SRD, SFD};

    for (genvar i = 0; i < N_SENS; i++) begin : g_deb
        sh_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clk   (clk),
            .rst_n (Rst),
            .raw   (sens_raw[i]),
            .filt  (sens_f[i])
        );
    end

    assign {sw_f, sfa_f, srd_f, sfd_f} = sens_f;

    // Stage p0: registered temperature, state and zone
    logic [TEMP_W-1:0] st_p0;
    state_t            state;
    state_t            state_nxt;
    logic              fire_nxt;
    logic [ZONE_W-1:0] zone_nxt;

`ifdef SH_FIRE_LATCH_EN
    // Once in FIRE, only an ack with the sensor already clear releases it.
    assign fire_nxt = sfa_f | ((state == S_FIRE) & ~(alarm_ack & ~sfa_f));
`else
    logic unused_ack;
    assign unused_ack = alarm_ack;
    assign fire_nxt   = sfa_f;
`endif

    always_comb begin
        zone_nxt = '0;
        for (int i = N_WIN - 1; i >= 0; i--) begin
            if (sw_f[i]) zone_nxt = ZONE_W'(i);
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        if (logic'(3'(state) == 3'b111)) begin
            state_nxt = S_IDLE;
        end else if (fire_nxt) begin
            state_nxt = S_FIRE;
        end else if (sfd_f) begin
            state_nxt = S_FRONT;
        end else if (srd_f) begin
            state_nxt = S_REAR;
        end else if (|sw_f) begin
            state_nxt = S_WIN;
        end else if ((state == S_HEAT) ? (st_p0 < HEAT_OFF) : (st_p0 < HEAT_ON)) begin
            state_nxt = S_HEAT;
        end else if ((state == S_COOL) ? (st_p0 > COOL_OFF) : (st_p0 > COOL_ON)) begin
            state_nxt = S_COOL;
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Zone loads on the same edge the FSM enters WIN so it lines up with winbuzz.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            st_p0    <= '0;
            win_zone <= '0;
        end else begin
            st_p0 <= ST;
            if (state_nxt == S_WIN) win_zone <= zone_nxt;
        end
    end

    assign fdoor     = (state == S_FRONT);
    assign rdoor     = (state == S_REAR);
    assign winbuzz   = (state == S_WIN);
    assign alarmbuzz = (state == S_FIRE);
    assign heater    = (state == S_HEAT);
    assign cooler    = (state == S_COOL);
    assign display   = state;

endmodule

// File: tb/tb_smart_home_ctrl_p.sv
// Directed bench for smart_home_ctrl_p with a history-window reference model.
module tb_smart_home_ctrl_p;

    localparam int N_WIN  = 4;
    localparam int DEB    = 4;
    localparam int T_LOW  = 50;
    localparam int T_HIGH = 60;
    localparam int HYST   = 2;
    localparam int NS     = 3 + N_WIN;

    logic             clk = 1'b0;
    logic             Rst = 1'b0;
    logic             SFD = 1'b0;
    logic             SRD = 1'b0;
    logic             SFA = 1'b0;
    logic             alarm_ack = 1'b0;
    logic [N_WIN-1:0] SW = '0;
    logic [6:0]       ST = 7'd55;

    logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
    logic [1:0] win_zone;
    logic [2:0] display;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    smart_home_ctrl_p dut (
        .clk       (clk),
        .Rst       (Rst),
        .SFD       (SFD),
        .SRD       (SRD),
        .SW        (SW),
        .SFA       (SFA),
        .ST        (ST),
        .alarm_ack (alarm_ack),
        .fdoor     (fdoor),
        .rdoor     (rdoor),
        .winbuzz   (winbuzz),
        .win_zone  (win_zone),
        .alarmbuzz (alarmbuzz),
        .heater    (heater),
        .cooler    (cooler),
        .display   (display)
    );

    // Reference model: state codes 0..6 as displayed, filtered sensors derived
    // from a history of raw samples (accept when the last DEB synced samples all differ).
    int          m_state = 0;
    int          m_zone  = 0;
    int          m_tq    = 0;
    logic [NS-1:0] m_f   = '0;
    logic [NS-1:0] hist [0:15];

    initial begin : model
        int            ns;
        bit            fire, heat_c, cool_c, all_diff;
        logic [NS-1:0] nf;
        for (int j = 0; j < 16; j++) hist[j] = '0;
        forever begin
            @(posedge clk or negedge Rst);
            if (!Rst) begin
                m_state = 0;
                m_zone  = 0;
                m_tq    = 0;
                m_f     = '0;
                for (int j = 0; j < 16; j++) hist[j] = '0;
            end else begin
`ifdef SH_FIRE_LATCH_EN
                fire = m_f[2] || (m_state == 3 && !(alarm_ack && !m_f[2]));
`else
                fire = m_f[2];
`endif
                heat_c = (m_state == 5) ? (m_tq < T_LOW + HYST) : (m_tq < T_LOW);
                cool_c = (m_state == 6) ? (m_tq > T_HIGH - HYST) : (m_tq > T_HIGH);
                if (fire)                  ns = 3;
                else if (m_f[0])           ns = 1;
                else if (m_f[1])           ns = 2;
                else if (m_f[NS-1:3] != 0) ns = 4;
                else if (heat_c)           ns = 5;
                else if (cool_c)           ns = 6;
                else                       ns = 0;
                if (ns == 4) begin
                    for (int i = 0; i < N_WIN; i++) begin
                        if (m_f[3+i]) begin
                            m_zone = i;
                            break;
                        end
                    end
                end
                nf = m_f;
                for (int b = 0; b < NS; b++) begin
                    all_diff = 1'b1;
                    for (int j = 1; j <= DEB; j++) if (hist[j][b] == m_f[b]) all_diff = 1'b0;
                    if (all_diff) nf[b] = ~m_f[b];
                end
                for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = {SW, SFA, SRD, SFD};
                m_f     = nf;
                m_state = ns;
                m_tq    = int'(ST);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic pin(input string name, input int act, input int mdl, input int exp);
        check(name, act, exp);
        check({name, "_model"}, mdl, exp);
    endtask

    task automatic compare_all();
        check("fdoor",     int'(fdoor),     int'(m_state == 1));
        check("rdoor",     int'(rdoor),     int'(m_state == 2));
        check("alarmbuzz", int'(alarmbuzz), int'(m_state == 3));
        check("winbuzz",   int'(winbuzz),   int'(m_state == 4));
        check("heater",    int'(heater),    int'(m_state == 5));
        check("cooler",    int'(cooler),    int'(m_state == 6));
        check("display",   int'(display),   m_state);
        check("win_zone",  int'(win_zone),  m_zone);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_all();
        end
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        tick(3);
        pin("rst_display", int'(display), m_state, 0);
        Rst = 1'b1;
        tick(3);
        pin("idle_display", int'(display), m_state, 0);

        // Heating / cooling thresholds and hysteresis
        ST = 7'd49;
        tick(1);  pin("heat_lat1", int'(heater), int'(m_state == 5), 0);
        tick(1);  pin("heat_on",   int'(heater), int'(m_state == 5), 1);
        ST = 7'd51;
        tick(3);  pin("heat_hold51", int'(heater), int'(m_state == 5), 1);
        ST = 7'd52;
        tick(2);  pin("heat_off52", int'(heater), int'(m_state == 5), 0);
        ST = 7'd61;
        tick(2);  pin("cool_on61", int'(display), m_state, 6);
        ST = 7'd59;
        tick(3);  pin("cool_hold59", int'(cooler), int'(m_state == 6), 1);
        ST = 7'd58;
        tick(2);  pin("cool_off58", int'(cooler), int'(m_state == 6), 0);
        ST = 7'd50;
        tick(3);  pin("no_heat50", int'(heater), int'(m_state == 5), 0);
        ST = 7'd60;
        tick(3);  pin("no_cool60", int'(display), m_state, 0);

        // Pre-emption out of HEAT drops the hysteresis band
        ST = 7'd49;
        tick(2);  pin("heat_again", int'(heater), int'(m_state == 5), 1);
        ST  = 7'd51;
        SFD = 1'b1;
        tick(7);  pin("front_preempt", int'(display), m_state, 1);
        SFD = 1'b0;
        tick(7);  pin("no_reentry51", int'(display), m_state, 0);

        // Asynchronous reset in the middle of HEAT
        ST = 7'd49;
        tick(3);  pin("heat_before_rst", int'(heater), int'(m_state == 5), 1);
        Rst = 1'b0;
        #1;
        pin("async_rst_heater",  int'(heater),  int'(m_state == 5), 0);
        pin("async_rst_display", int'(display), m_state, 0);
        tick(3);
        Rst = 1'b1;
        ST  = 7'd55;
        tick(4);  pin("post_rst_idle", int'(display), m_state, 0);

        // Front door with windows pending, then window zones
        SFD = 1'b1;
        SW  = 4'b0110;
        tick(6);  pin("front_lat6", int'(display), m_state, 0);
        tick(1);  pin("front_lat7", int'(display), m_state, 1);
        SFD = 1'b0;
        tick(6);  pin("front_hold", int'(fdoor), int'(m_state == 1), 1);
        tick(1);  pin("win_on", int'(winbuzz), int'(m_state == 4), 1);
        pin("win_zone1", int'(win_zone), m_zone, 1);
        SW = 4'b1001;
        tick(7);  pin("win_zone0", int'(win_zone), m_zone, 0);
        SW = 4'b1000;
        tick(7);  pin("win_zone3", int'(win_zone), m_zone, 3);
        SW = 4'b0000;
        tick(7);  pin("win_off", int'(display), m_state, 0);
        pin("win_zone_hold", int'(win_zone), m_zone, 3);

        // Rear door glitch rejection and a qualifying pulse
        SRD = 1'b1;
        tick(3);
        SRD = 1'b0;
        tick(8);  pin("glitch_rej", int'(rdoor), int'(m_state == 2), 0);
        SRD = 1'b1;
        tick(6);  pin("rear_lat6", int'(rdoor), int'(m_state == 2), 0);
        tick(1);  pin("rear_on", int'(display), m_state, 2);
        SRD = 1'b0;
        tick(6);  pin("rear_hold", int'(rdoor), int'(m_state == 2), 1);
        tick(1);  pin("rear_off", int'(display), m_state, 0);

        // Fire with a rear-door event pending underneath
        SFA = 1'b1;
        SRD = 1'b1;
        tick(7);  pin("fire_on", int'(display), m_state, 3);
        pin("fire_masks_rear", int'(rdoor), int'(m_state == 2), 0);
        alarm_ack = 1'b1;
        tick(1);
        alarm_ack = 1'b0;
        tick(1);  pin("ack_ignored", int'(alarmbuzz), int'(m_state == 3), 1);
        SFA       = 1'b0;
        alarm_ack = 1'b1;
        tick(1);
        alarm_ack = 1'b0;
        tick(5);  pin("fire_hold", int'(alarmbuzz), int'(m_state == 3), 1);
        tick(1);
`ifdef SH_FIRE_LATCH_EN
        pin("fire_latched", int'(alarmbuzz), int'(m_state == 3), 1);
        tick(3);  pin("fire_latched2", int'(display), m_state, 3);
        alarm_ack = 1'b1;
        tick(1);  pin("fire_ack_exit", int'(display), m_state, 2);
        alarm_ack = 1'b0;
`else
        pin("fire_follow_exit", int'(alarmbuzz), int'(m_state == 3), 0);
        pin("rear_served", int'(display), m_state, 2);
`endif
        SRD = 1'b0;
        tick(7);  pin("final_idle", int'(display), m_state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
